// File: rtl/fft_bitrev_reorder.sv
// Reorders the FFT bit-reversed output stream into natural bin order.
// Frames are buffered in two ping-pong banks and streamed out over valid/ready.
module fft_bitrev_reorder #(
  parameter int FFT_N     = 1024,
  parameter int FFT_NLOG2 = 10,
  parameter int DW        = 25
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sync_i,
  input  logic [FFT_NLOG2-1:0]        data_cnt_i,
  input  logic signed [DW-1:0]        data_re_i,
  input  logic signed [DW-1:0]        data_im_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [FFT_NLOG2-1:0]        bin_o,
  output logic                        last_o,
  output logic signed [DW-1:0]        data_re_o,
  output logic signed [DW-1:0]        data_im_o,
  output logic                        overflow_o
);

  localparam logic [FFT_NLOG2-1:0] IDX_LAST = FFT_NLOG2'(FFT_N - 1);
  localparam logic [FFT_NLOG2-1:0] IDX_ONE  = FFT_NLOG2'(1);
  localparam logic [FFT_NLOG2-1:0] IDX_ZERO = '0;

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_t;
  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wr_state_t;
  typedef enum logic {R_IDLE, R_READ} rd_state_t;

  bank_t bank_st [2];
  logic  older_full;
  logic  free0, free1, full0, full1;
  logic  free_any, full_any, free_sel, full_sel;

  wr_state_t              wr_state, wr_next;
  logic [FFT_NLOG2-1:0]   wr_cnt;
  logic                   wr_bank;
  logic                   wr_last;
  logic                   wr_take, wr_drop_start, wr_en, wr_done, wr_abort;
  logic                   wr_bank_sel;

  rd_state_t              rd_state, rd_next;
  logic [FFT_NLOG2-1:0]   rd_addr;
  logic                   rd_bank;
  logic                   rd_at_last;
  logic                   rd_take, rd_issue, rd_release;
  logic                   rd_bank_cur;
  logic [FFT_NLOG2-1:0]   rd_addr_cur;

  logic [2*DW-1:0]        mem [0:2*FFT_N-1];
  logic [2*DW-1:0]        ram_q;
  logic                   s1_v;
  logic [FFT_NLOG2-1:0]   s1_bin;
  logic                   s1_last;
  logic                   s2_accept, can_issue;

  assign free0    = (bank_st[0] == B_FREE);
  assign free1    = (bank_st[1] == B_FREE);
  assign full0    = (bank_st[0] == B_FULL);
  assign full1    = (bank_st[1] == B_FULL);
  assign free_any = free0 | free1;
  assign full_any = full0 | full1;
  assign free_sel = !free0;
  assign full_sel = (full0 && full1) ? older_full : !full0;

  // ---------------- writer FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) wr_state <= W_IDLE;
    else       wr_state <= wr_next;
  end

  assign wr_last = (wr_cnt == IDX_LAST);

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (sync_i) wr_next = free_any ? W_WRITE : W_DROP;
      W_WRITE: if (!sync_i || wr_last) wr_next = W_IDLE;
      W_DROP:  if (!sync_i || wr_last) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    wr_take       = (wr_state == W_IDLE) && sync_i && free_any;
    wr_drop_start = (wr_state == W_IDLE) && sync_i && !free_any;
    wr_en         = wr_take || ((wr_state == W_WRITE) && sync_i);
    wr_done       = (wr_state == W_WRITE) && sync_i && wr_last;
    wr_abort      = (wr_state == W_WRITE) && !sync_i;
    wr_bank_sel   = wr_take ? free_sel : wr_bank;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt     <= IDX_ZERO;
      wr_bank    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= wr_drop_start;
      case (wr_state)
        W_IDLE: begin
          if (sync_i) wr_cnt <= IDX_ONE;
          if (wr_take) wr_bank <= free_sel;
        end
        W_WRITE, W_DROP: begin
          if (!sync_i || wr_last) wr_cnt <= IDX_ZERO;
          else                    wr_cnt <= wr_cnt + IDX_ONE;
        end
        default: wr_cnt <= IDX_ZERO;
      endcase
    end
  end

  // ---------------- reader FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_state <= R_IDLE;
    else       rd_state <= rd_next;
  end

  assign rd_at_last = (rd_addr == IDX_LAST);

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (full_any) rd_next = R_READ;
      R_READ:  if (rd_issue && rd_at_last) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // A bank claimed from IDLE issues address 0 on the same edge, so frames
  // follow each other without a bubble.
  always_comb begin
    rd_take     = (rd_state == R_IDLE) && full_any;
    rd_issue    = can_issue && (rd_take || (rd_state == R_READ));
    rd_release  = (rd_state == R_READ) && rd_issue && rd_at_last;
    rd_bank_cur = rd_take ? full_sel : rd_bank;
    rd_addr_cur = rd_take ? IDX_ZERO : rd_addr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_addr <= IDX_ZERO;
      rd_bank <= 1'b0;
    end else if (rd_take) begin
      rd_bank <= full_sel;
      rd_addr <= rd_issue ? IDX_ONE : IDX_ZERO;
    end else if ((rd_state == R_READ) && rd_issue) begin
      rd_addr <= rd_at_last ? IDX_ZERO : rd_addr + IDX_ONE;
    end
  end

  // ---------------- bank bookkeeping ----------------
  // Writer and reader only move a bank out of disjoint states, so the two
  // never update the same bank on one edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_st[0] <= B_FREE;
      bank_st[1] <= B_FREE;
      older_full <= 1'b0;
    end else begin
      if (wr_take)  bank_st[free_sel] <= B_FILLING;
      if (wr_done) begin
        bank_st[wr_bank] <= B_FULL;
        if (bank_st[!wr_bank] == B_FULL) older_full <= !wr_bank;
      end
      if (wr_abort)   bank_st[wr_bank]  <= B_FREE;
      if (rd_take)    bank_st[full_sel] <= B_READING;
      if (rd_release) bank_st[rd_bank]  <= B_FREE;
    end
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk_i) begin
    if (wr_en)    mem[{wr_bank_sel, data_cnt_i}] <= {data_re_i, data_im_i};
    if (rd_issue) ram_q <= mem[{rd_bank_cur, rd_addr_cur}];
  end

  // ---------------- output pipeline ----------------
  // ram_q only changes on a read issue, so it doubles as the skid stage.
  assign s2_accept = !valid_o || ready_i;
  assign can_issue = !s1_v || s2_accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_v    <= 1'b0;
      s1_bin  <= IDX_ZERO;
      s1_last <= 1'b0;
    end else if (rd_issue) begin
      s1_v    <= 1'b1;
      s1_bin  <= rd_addr_cur;
      s1_last <= (rd_addr_cur == IDX_LAST);
    end else if (s2_accept) begin
      s1_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      bin_o     <= IDX_ZERO;
      last_o    <= 1'b0;
      data_re_o <= '0;
      data_im_o <= '0;
    end else if (s2_accept) begin
      valid_o <= s1_v;
      last_o  <= s1_v && s1_last;
      if (s1_v) begin
        bin_o     <= s1_bin;
        data_re_o <= ram_q[2*DW-1:DW];
        data_im_o <= ram_q[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: frame reorder, back-to-back,
// backpressure, overflow, abort and mid-readout reset.
module tb_fft_bitrev_reorder;

  localparam int N  = 1024;
  localparam int LG = 10;
  localparam int DW = 25;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 sync_in = 1'b0;
  logic [LG-1:0]        data_cnt = '0;
  logic signed [DW-1:0] re_in = '0;
  logic signed [DW-1:0] im_in = '0;
  logic                 ready = 1'b1;
  logic                 valid;
  logic [LG-1:0]        bin;
  logic                 last;
  logic signed [DW-1:0] re_out;
  logic signed [DW-1:0] im_out;
  logic                 ovf;

  fft_bitrev_reorder #(.FFT_N(N), .FFT_NLOG2(LG), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .sync_i(sync_in), .data_cnt_i(data_cnt),
    .data_re_i(re_in), .data_im_i(im_in), .ready_i(ready),
    .valid_o(valid), .bin_o(bin), .last_o(last),
    .data_re_o(re_out), .data_im_o(im_out), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   cyc;
    logic                 v, r, l, o;
    logic [LG-1:0]        b;
    logic signed [DW-1:0] re, im;
  } rec_t;

  rec_t log_q[$];
  rec_t acc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;   // 0: always 1, 1: 1,0,0,0 pattern, 2: always 0
  int   phase = 0;
  int   first_drive_cyc = 0;
  int   last_drive_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle recorder: samples outputs, then drives ready for the next edge.
  initial begin
    rec_t rec;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = (phase % 4 == 0);
        default: ready = 1'b0;
      endcase
      phase++;
      rec.cyc = cyc; rec.v = valid; rec.r = ready; rec.l = last; rec.o = ovf;
      rec.b = bin; rec.re = re_out; rec.im = im_out;
      log_q.push_back(rec);
      if (valid && ready) acc_q.push_back(rec);
    end
  end

  function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] x);
    logic [LG-1:0] r;
    for (int i = 0; i < LG; i++) r[i] = x[LG-1-i];
    return r;
  endfunction

  task automatic clear_logs();
    log_q.delete();
    acc_q.delete();
    phase = 0;
  endtask

  task automatic drive_samples(input int frame, input int count);
    logic [LG-1:0] idx;
    logic [LG-1:0] br;
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      if (i == 0) first_drive_cyc = cyc;
      idx      = i[LG-1:0];
      br       = bitrev(idx);
      sync_in  = 1'b1;
      data_cnt = br;
      re_in    = DW'(frame * N + int'(br));
      im_in    = DW'(-(frame * N + int'(br)));
      last_drive_cyc = cyc;
    end
  endtask

  task automatic drive_idle();
    @(negedge clk);
    sync_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready_mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got %0b want 0", last); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", ovf); end
    checks++; if (bin !== '0) begin errors++; $display("FAIL reset_bin got %0d want 0", bin); end
    checks++; if (re_out !== '0) begin errors++; $display("FAIL reset_re got %0d want 0", re_out); end
    checks++; if (im_out !== '0) begin errors++; $display("FAIL reset_im got %0d want 0", im_out); end
  endtask

  task automatic test_single_frame();
    bit bad = 0;
    int first_v = -1;
    int ovf_cnt = 0;
    ready_mode = 0;
    clear_logs();
    drive_samples(0, N);
    drive_idle();
    repeat (N + 20) @(negedge clk);
    checks++;
    if (acc_q.size() != N) begin errors++; $display("FAIL single_count got %0d want %0d", acc_q.size(), N); end
    foreach (log_q[i]) begin
      if (log_q[i].v && first_v < 0) first_v = log_q[i].cyc;
      if (log_q[i].o) ovf_cnt++;
    end
    checks++;
    if (first_v != last_drive_cyc + 3) begin
      errors++; $display("FAIL single_latency first valid cyc %0d want %0d", first_v, last_drive_cyc + 3);
    end
    checks++;
    if (ovf_cnt != 0) begin errors++; $display("FAIL single_overflow pulses %0d want 0", ovf_cnt); end
    foreach (acc_q[k]) begin
      if (!bad) begin
        checks++;
        if (acc_q[k].b !== LG'(k) || acc_q[k].re !== DW'(k) || acc_q[k].im !== DW'(-k) ||
            acc_q[k].l !== (k == N - 1)) begin
          errors++; bad = 1;
          $display("FAIL single_data idx %0d got bin %0d re %0d im %0d last %0b want bin %0d re %0d im %0d last %0b",
                   k, acc_q[k].b, acc_q[k].re, acc_q[k].im, acc_q[k].l, k, k, -k, (k == N - 1));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit bad = 0;
    bit gap = 0;
    int ovf_cnt = 0;
    ready_mode = 0;
    clear_logs();
    for (int f = 0; f < 3; f++) drive_samples(f, N);
    drive_idle();
    repeat (N + 20) @(negedge clk);
    checks++;
    if (acc_q.size() != 3 * N) begin errors++; $display("FAIL b2b_count got %0d want %0d", acc_q.size(), 3 * N); end
    foreach (log_q[i]) if (log_q[i].o) ovf_cnt++;
    checks++;
    if (ovf_cnt != 0) begin errors++; $display("FAIL b2b_overflow pulses %0d want 0", ovf_cnt); end
    foreach (acc_q[k]) begin
      if (!bad) begin
        checks++;
        if (acc_q[k].b !== LG'(k % N) || acc_q[k].re !== DW'(k) || acc_q[k].im !== DW'(-k) ||
            acc_q[k].l !== ((k % N) == N - 1)) begin
          errors++; bad = 1;
          $display("FAIL b2b_data idx %0d got bin %0d re %0d want bin %0d re %0d", k, acc_q[k].b, acc_q[k].re, k % N, k);
        end
      end
      if (k > 0 && !gap) begin
        checks++;
        if (acc_q[k].cyc != acc_q[k-1].cyc + 1) begin
          errors++; gap = 1;
          $display("FAIL b2b_gap idx %0d at cyc %0d want cyc %0d", k, acc_q[k].cyc, acc_q[k-1].cyc + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit bad = 0;
    bit unstable = 0;
    ready_mode = 1;
    clear_logs();
    drive_samples(7, N);
    drive_idle();
    repeat (4 * N + 40) @(negedge clk);
    checks++;
    if (acc_q.size() != N) begin errors++; $display("FAIL bp_count got %0d want %0d", acc_q.size(), N); end
    foreach (acc_q[k]) begin
      if (!bad) begin
        checks++;
        if (acc_q[k].b !== LG'(k) || acc_q[k].re !== DW'(7 * N + k) || acc_q[k].im !== DW'(-(7 * N + k)) ||
            acc_q[k].l !== (k == N - 1)) begin
          errors++; bad = 1;
          $display("FAIL bp_data idx %0d got bin %0d re %0d want bin %0d re %0d", k, acc_q[k].b, acc_q[k].re, k, 7 * N + k);
        end
      end
    end
    for (int i = 0; i + 1 < log_q.size(); i++) begin
      if (log_q[i].v && !log_q[i].r && !unstable) begin
        checks++;
        if (log_q[i+1].v !== 1'b1 || log_q[i+1].b !== log_q[i].b || log_q[i+1].re !== log_q[i].re ||
            log_q[i+1].im !== log_q[i].im || log_q[i+1].l !== log_q[i].l) begin
          errors++; unstable = 1;
          $display("FAIL bp_stall_hold cyc %0d got v %0b bin %0d want v 1 bin %0d", log_q[i+1].cyc, log_q[i+1].v, log_q[i+1].b, log_q[i].b);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit bad = 0;
    int pulses = 0;
    int pulse_cyc = -1;
    int f3_first;
    ready_mode = 2;
    clear_logs();
    drive_samples(10, N);
    drive_samples(11, N);
    drive_samples(12, N);
    f3_first = first_drive_cyc;
    drive_idle();
    repeat (10) @(negedge clk);
    foreach (log_q[i]) if (log_q[i].o) begin pulses++; pulse_cyc = log_q[i].cyc; end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", pulses); end
    checks++;
    if (pulse_cyc != f3_first + 1) begin errors++; $display("FAIL ovf_timing got cyc %0d want %0d", pulse_cyc, f3_first + 1); end
    checks++;
    if (acc_q.size() != 0) begin errors++; $display("FAIL ovf_stalled accepted %0d want 0", acc_q.size()); end
    clear_logs();
    ready_mode = 0;
    repeat (2 * N + 20) @(negedge clk);
    checks++;
    if (acc_q.size() != 2 * N) begin errors++; $display("FAIL ovf_drain_count got %0d want %0d", acc_q.size(), 2 * N); end
    foreach (acc_q[k]) begin
      if (!bad) begin
        checks++;
        if (acc_q[k].b !== LG'(k % N) || acc_q[k].re !== DW'(10 * N + k) || acc_q[k].im !== DW'(-(10 * N + k))) begin
          errors++; bad = 1;
          $display("FAIL ovf_drain_data idx %0d got bin %0d re %0d want bin %0d re %0d", k, acc_q[k].b, acc_q[k].re, k % N, 10 * N + k);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit bad = 0;
    int pulses = 0;
    ready_mode = 0;
    clear_logs();
    drive_samples(20, 500);
    drive_idle();
    repeat (3) @(negedge clk);
    drive_samples(21, N);
    drive_idle();
    repeat (N + 20) @(negedge clk);
    foreach (log_q[i]) if (log_q[i].o) pulses++;
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL abort_overflow pulses %0d want 0", pulses); end
    checks++;
    if (acc_q.size() != N) begin errors++; $display("FAIL abort_count got %0d want %0d", acc_q.size(), N); end
    foreach (acc_q[k]) begin
      if (!bad) begin
        checks++;
        if (acc_q[k].b !== LG'(k) || acc_q[k].re !== DW'(21 * N + k) || acc_q[k].im !== DW'(-(21 * N + k))) begin
          errors++; bad = 1;
          $display("FAIL abort_data idx %0d got bin %0d re %0d want bin %0d re %0d", k, acc_q[k].b, acc_q[k].re, k, 21 * N + k);
        end
      end
    end
  endtask

  task automatic test_reset_mid_readout();
    bit bad = 0;
    bit found = 0;
    int vcnt = 0;
    ready_mode = 0;
    clear_logs();
    drive_samples(30, N);
    drive_idle();
    for (int t = 0; t < 2000 && !found; t++) begin
      @(negedge clk);
      if (valid && bin == LG'(300)) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_reach bin 300 not seen within bound, got bin %0d", bin); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (valid !== 1'b0 || last !== 1'b0 || ovf !== 1'b0 || bin !== '0 || re_out !== '0 || im_out !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got v %0b last %0b ovf %0b bin %0d re %0d im %0d want all 0", valid, last, ovf, bin, re_out, im_out);
    end
    clear_logs();
    repeat (N + 20) @(negedge clk);
    foreach (log_q[i]) if (log_q[i].v) vcnt++;
    checks++;
    if (vcnt != 0) begin errors++; $display("FAIL rstmid_silent valid cycles %0d want 0", vcnt); end
    clear_logs();
    drive_samples(31, N);
    drive_idle();
    repeat (N + 20) @(negedge clk);
    checks++;
    if (acc_q.size() != N) begin errors++; $display("FAIL rstmid_new_count got %0d want %0d", acc_q.size(), N); end
    foreach (acc_q[k]) begin
      if (!bad) begin
        checks++;
        if (acc_q[k].b !== LG'(k) || acc_q[k].re !== DW'(31 * N + k) || acc_q[k].im !== DW'(-(31 * N + k))) begin
          errors++; bad = 1;
          $display("FAIL rstmid_new_data idx %0d got bin %0d re %0d want bin %0d re %0d", k, acc_q[k].b, acc_q[k].re, k, 31 * N + k);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_abort();
    test_reset_mid_readout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Reorders the FFT's bit-reversed output stream into natural frequency-bin order. The block sits directly downstream of the radix-2² SDF FFT and accepts its `sync`/`data_cnt`/`re`/`im` stream. It buffers each frame in one of two ping-pong RAM banks and streams the frame out as bins 0..FFT_N-1 over a valid/ready interface. Downstream consumers are the windowed-bin selector and the host transfer path.

## Interface
- `FFT_N`, 1024, frame length in samples; power of 2.
- `FFT_NLOG2`, 10, log2(FFT_N).
- `DW`, 25, width of each real and imaginary sample.
- `clk_i`  in  1  sole clock; all logic on posedge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `sync_i`  in  1  input sample valid (FFT `sync_o`); stays high across back-to-back frames.
- `data_cnt_i`  in  FFT_NLOG2  bin index of the current input sample (already bit-reversed by the FFT); used as the RAM write address.
- `data_re_i`, `data_im_i`  in  DW signed  input sample.
- `ready_i`  in  1  downstream accepts the output on this edge when `valid_o` is high.
- `valid_o`  out  1  output sample valid.
- `bin_o`  out  FFT_NLOG2  natural-order bin index of the output sample.
- `last_o`  out  1  high with bin FFT_N-1.
- `data_re_o`, `data_im_o`  out  DW signed  output sample.
- `overflow_o`  out  1  one-cycle pulse when an input frame is dropped.

## Operation
- Storage: 2 banks, each FFT_N × 2·DW, with synchronous read (1-cycle latency). RAM contents are not reset.
- Each bank is in one of four states: FREE, FILLING, FULL, READING. After reset both banks are FREE.
- Writer FSM has three states: IDLE, WRITE, DROP. It holds an internal sample counter `wr_cnt` (0..FFT_N-1).
  - IDLE, on `sync_i`=1:
    - If a FREE bank exists, take it (bank 0 preferred on a tie), mark it FILLING, write the sample at `data_cnt_i`, set `wr_cnt`=1, and enter WRITE.
    - Otherwise pulse `overflow_o`, set `wr_cnt`=1, and enter DROP.
  - WRITE: each `sync_i` sample is written at `data_cnt_i` and increments `wr_cnt`. The sample with `wr_cnt`=FFT_N-1 completes the frame: the bank becomes FULL and the writer returns to IDLE.
  - DROP: count samples without writing. At `wr_cnt`=FFT_N-1, return to IDLE.
  - `sync_i`=0 in WRITE or DROP aborts the frame: the bank returns to FREE, `wr_cnt`=0, the writer goes to IDLE, nothing is output, and `overflow_o` is not raised.
- Reader FSM has two states: IDLE, READ. It holds `rd_addr` (natural order).
  - IDLE: when a FULL bank exists, mark it READING, set `rd_addr`=0, and enter READ. The oldest FULL bank is served first.
  - READ: issue RAM reads at `rd_addr`, 0..FFT_N-1, advancing only when the output stage can accept a word.
  - The edge that issues the read of address FFT_N-1 marks the bank FREE. That bank is writable from the next edge.
  - The reader returns to IDLE, or enters READ on the other bank if that bank is FULL, with no gap.
- Output stage is one output register (skid as needed).
  - While `valid_o`=1 and `ready_i`=0, `data_*_o`, `bin_o` and `last_o` hold stable.
  - No sample is lost or duplicated for any `ready_i` pattern.
- Arithmetic: none. Data passes bit-exact; `bin_o` equals the RAM read address.

## Timing
- Reset values: `valid_o`=0, `last_o`=0, `overflow_o`=0, `bin_o`=0, `data_re_o`=`data_im_o`=0. Both banks FREE, both FSMs IDLE, counters 0.
- `rst_i` mid-frame or mid-readout: all outputs take their reset values on the next edge, and partial frames are discarded.
- Latency: with `ready_i`=1, the final sample of a frame is captured on edge k. The read of bin 0 issues on edge k+1, and `valid_o`/bin 0 appear after edge k+2.
- Throughput: one output per cycle while `ready_i`=1.
- Back-to-back frames with `ready_i` held high never overflow:
  - bank release on the last read-issue edge precedes the next frame's first write by ≥1 cycle.
  - output is continuous across frames.
- `overflow_o` is high for exactly the cycle after the edge that samples the first sample of a dropped frame.

## Test plan
- Reset, then one frame where the sample with `data_cnt_i`=j has re=j, im=-j → 1024 outputs with bin_o=0..1023, data_re_o=bin_o, data_im_o=-bin_o, last_o only on bin 1023, first valid_o 2 edges after the last input.
- Three back-to-back frames (re = frame·1024 + j), `ready_i`=1 → 3072 contiguous outputs in order, no gap between frames, overflow_o never asserted.
- One frame with `ready_i` pattern 1,0,0,0 repeating → all 1024 bins in order, outputs stable during stalls, no duplicates.
- `ready_i`=0 throughout three back-to-back frames → single overflow_o pulse at frame 3's first sample. Then `ready_i`=1 → frames 1 and 2 only, in order.
- `sync_i` dropped after 500 samples, then a full frame → only the full frame is output, overflow_o=0.
- `rst_i` pulsed at bin 300 of readout → valid_o=0 and all outputs zero next edge; no output until a new full frame arrives.
